hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the five-stage processor (IF, DEC, EX, MEM, WB). It generates hold and flush controls for the PC and the four pipeline registers, and EX operand forwarding selects. It sequences multi-cycle multiplies occupying EX, load-use interlocks, taken-branch squashes and data-memory wait states. It sits beside the datapath in PROCESSOR and drives the PIPE enables and clears.

Parameters:
MUL_CYCLES, 4, number of cycles a MULOp instruction occupies EX (legal range 1..16)
CNT_W, 16, width of the stall performance counter

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
RsAddrD  in  5  Rs field of the instruction in DEC
RtAddrD  in  5  Rt field of the instruction in DEC
UsesRsD  in  1  DEC instruction reads Rs
UsesRtD  in  1  DEC instruction reads Rt
RsAddrE  in  5  Rs of the instruction in EX
RtAddrE  in  5  Rt of the instruction in EX
RAddrE  in  5  destination register in EX
RegWriteE  in  1  EX instruction writes a register
MemReadE  in  1  EX instruction is a load
MULOpE  in  1  EX instruction is a multiply
BranchTakenE  in  1  branch in EX resolved taken
RAddrM  in  5  destination register in MEM
RegWriteM  in  1  MEM instruction writes a register
RAddrW  in  5  destination register in WB
RegWriteW  in  1  WB instruction writes a register
MemBusyM  in  1  data memory not ready this cycle
HoldPC  out  1  PC keeps its value
HoldFD  out  1  IF/DEC register keeps its value
HoldDE  out  1  DEC/EX register keeps its value
HoldEM  out  1  EX/MEM register keeps its value
FlushFD  out  1  IF/DEC loads a bubble
FlushDE  out  1  DEC/EX loads a bubble
FlushEM  out  1  EX/MEM loads a bubble
FlushMW  out  1  MEM/WB loads a bubble
FwdA  out  2  EX operand A select: 00 register file, 01 WB, 10 MEM
FwdB  out  2  EX operand B select, same encoding
MulBusy  out  1  multiply is stalling the pipe this cycle
StallCycles  out  CNT_W  count of cycles with HoldPC=1

Behaviour:
- Forwarding (combinational): FwdA=10 if RegWriteM, RAddrM!=0 and RAddrM==RsAddrE; otherwise 01 if RegWriteW, RAddrW!=0 and RAddrW==RsAddrE; otherwise 00. MEM beats WB. FwdB uses RtAddrE in the same way.
- Register 0 never matches for forwarding or the interlock.
- FSM states: IDLE, MUL. Mul counter Count is 4 bits.
  - IDLE with MULOpE and MUL_CYCLES>1: state<=MUL, Count<=MUL_CYCLES-2.
  - MUL with Count!=0: Count decrements.
  - MUL with Count==0: state<=IDLE.
  - MemBusyM=1 freezes state and Count.
- MulStall = (IDLE & MULOpE & MUL_CYCLES>1) | (MUL & Count!=0). This gives MUL_CYCLES-1 stall cycles per multiply; MUL_CYCLES=1 gives none. MulBusy = MulStall.
- LoadUse = MemReadE & RegWriteE & RAddrE!=0 & ((UsesRsD & RsAddrD==RAddrE) | (UsesRtD & RtAddrD==RAddrE)).
- Control priority, first match wins:
  1. Reset: Flush*=1, Hold*=0, FwdA=FwdB=00.
  2. MemBusyM: HoldPC, HoldFD, HoldDE, HoldEM =1; FlushMW=1. Any branch or interlock waits until release.
  3. MulStall: HoldPC, HoldFD, HoldDE =1; FlushEM=1.
  4. BranchTakenE: FlushFD=1, FlushDE=1. PC not held, so it loads the target. A simultaneous LoadUse is ignored because its consumer is squashed.
  5. LoadUse: HoldPC=1, HoldFD=1, FlushDE=1, for exactly one cycle.
  6. Otherwise all Hold/Flush =0.
- MULOpE & BranchTakenE together is illegal; flag it with a simulation assertion. RTL gives MulStall precedence.
- Hold and Flush are never both 1 for the same register.
- StallCycles increments on every cycle with HoldPC=1 and saturates at all-ones. Reset clears it.
- Reset mid-multiply: state<=IDLE, Count<=0, StallCycles<=0. In the first cycle after Reset falls, outputs follow the current inputs.

Test Plan:
- RegWriteM=1, RAddrM=5, RsAddrE=5; RegWriteW=1, RAddrW=5 -> FwdA=10. Same with RAddrM=0 -> FwdA=01. RtAddrE=7 with no match -> FwdB=00.
- Load r3 in EX (MemReadE=1, RegWriteE=1, RAddrE=3), DEC reads r3 via Rt -> exactly one cycle of HoldPC=HoldFD=FlushDE=1, then all 0. StallCycles +1.
- MUL_CYCLES=4, MULOpE held high -> MulBusy, HoldPC/FD/DE and FlushEM high for 3 cycles, low on the 4th. StallCycles=3.
- BranchTakenE=1 with LoadUse also true -> FlushFD=FlushDE=1, HoldPC=0, no load-use stall.
- Multiply in progress at Count=1, MemBusyM high for 2 cycles -> all four Holds and FlushMW=1, Count frozen. After release, one more MulBusy cycle, then free.
- Reset asserted mid-multiply -> next cycle state IDLE, StallCycles=0. During Reset all Flush=1, all Hold=0; forced StallCycles near all-ones saturates and does not wrap.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: stage holds and
// flushes, EX operand forwarding, multi-cycle multiply sequencing, stall counter.
module hazard_ctrl #(
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [4:0]       RsAddrD,
   input  logic [4:0]       RtAddrD,
   input  logic             UsesRsD,
   input  logic             UsesRtD,
   input  logic [4:0]       RsAddrE,
   input  logic [4:0]       RtAddrE,
   input  logic [4:0]       RAddrE,
   input  logic             RegWriteE,
   input  logic             MemReadE,
   input  logic             MULOpE,
   input  logic             BranchTakenE,
   input  logic [4:0]       RAddrM,
   input  logic             RegWriteM,
   input  logic [4:0]       RAddrW,
   input  logic             RegWriteW,
   input  logic             MemBusyM,
   output logic             HoldPC,
   output logic             HoldFD,
   output logic             HoldDE,
   output logic             HoldEM,
   output logic             FlushFD,
   output logic             FlushDE,
   output logic             FlushEM,
   output logic             FlushMW,
   output logic [1:0]       FwdA,
   output logic [1:0]       FwdB,
   output logic             MulBusy,
   output logic [CNT_W-1:0] StallCycles
);

   typedef enum logic {S_IDLE, S_MUL} state_t;

   localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
   localparam logic [3:0] MUL_LOAD  = MUL_MULTI ? 4'(MUL_CYCLES - 2) : 4'd0;

   state_t           state;
   state_t           state_next;
   logic [3:0]       count;
   logic [3:0]       count_next;
   logic             mul_stall;
   logic             load_use;
   logic [CNT_W-1:0] stall_cnt;

   // MEM holds the younger result, so it wins over WB; r0 is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic       wr_m,
      input logic [4:0] dst_m,
      input logic       wr_w,
      input logic [4:0] dst_w
   );
      if (wr_m && dst_m != 5'd0 && dst_m == src) return 2'b10;
      if (wr_w && dst_w != 5'd0 && dst_w == src) return 2'b01;
      return 2'b00;
   endfunction

   // The first stall cycle comes straight from IDLE, so a multiply stalls
   // MUL_CYCLES-1 cycles and advances on the last one.
   assign mul_stall = (state == S_IDLE && MULOpE && MUL_MULTI) ||
                      (state == S_MUL && count != 4'd0);

   assign load_use = MemReadE && RegWriteE && RAddrE != 5'd0 &&
                     ((UsesRsD && RsAddrD == RAddrE) || (UsesRtD && RtAddrD == RAddrE));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= S_IDLE;
         count <= 4'd0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // NOTE: every variable gets a default first so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      state_next = state;
      count_next = count;
      if (!MemBusyM) begin
         case (state)
            S_IDLE: begin
               if (MULOpE && MUL_MULTI) begin
                  state_next = S_MUL;
                  count_next = MUL_LOAD;
               end
            end
            S_MUL: begin
               if (count != 4'd0) count_next = count - 4'd1;
               else               state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      HoldPC  = 1'b0;
      HoldFD  = 1'b0;
      HoldDE  = 1'b0;
      HoldEM  = 1'b0;
      FlushFD = 1'b0;
      FlushDE = 1'b0;
      FlushEM = 1'b0;
      FlushMW = 1'b0;
      FwdA    = fwd_sel(RsAddrE, RegWriteM, RAddrM, RegWriteW, RAddrW);
      FwdB    = fwd_sel(RtAddrE, RegWriteM, RAddrM, RegWriteW, RAddrW);
      MulBusy = mul_stall && !Reset;
      if (Reset) begin
         FlushFD = 1'b1;
         FlushDE = 1'b1;
         FlushEM = 1'b1;
         FlushMW = 1'b1;
         FwdA    = 2'b00;
         FwdB    = 2'b00;
      end else if (MemBusyM) begin
         HoldPC  = 1'b1;
         HoldFD  = 1'b1;
         HoldDE  = 1'b1;
         HoldEM  = 1'b1;
         FlushMW = 1'b1;
      end else if (mul_stall) begin
         HoldPC  = 1'b1;
         HoldFD  = 1'b1;
         HoldDE  = 1'b1;
         FlushEM = 1'b1;
      end else if (BranchTakenE) begin
         // Any load-use consumer sits in DEC and is squashed here.
         FlushFD = 1'b1;
         FlushDE = 1'b1;
      end else if (load_use) begin
         HoldPC  = 1'b1;
         HoldFD  = 1'b1;
         FlushDE = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset)                                   stall_cnt <= '0;
      else if (HoldPC && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
   end

   assign StallCycles = stall_cnt;

   mul_branch_excl: assert property (@(posedge Clock) disable iff (Reset)
      !(MULOpE && BranchTakenE));

   hold_flush_excl: assert property (@(posedge Clock)
      !((HoldFD && FlushFD) || (HoldDE && FlushDE) || (HoldEM && FlushEM)));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus a
// rule-level model compared against every output on every cycle.
module tb_hazard_ctrl;

   localparam int MUL_CYCLES = 4;
   localparam int CNT_W      = 5;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic             Clock;
   logic             Reset;
   logic [4:0]       RsAddrD, RtAddrD, RsAddrE, RtAddrE, RAddrE, RAddrM, RAddrW;
   logic             UsesRsD, UsesRtD, RegWriteE, MemReadE, MULOpE, BranchTakenE;
   logic             RegWriteM, RegWriteW, MemBusyM;
   logic             HoldPC, HoldFD, HoldDE, HoldEM;
   logic             FlushFD, FlushDE, FlushEM, FlushMW;
   logic [1:0]       FwdA, FwdB;
   logic             MulBusy;
   logic [CNT_W-1:0] StallCycles;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: cycles the current multiply has spent in EX unfrozen, and stalls seen.
   int mul_age = 0;
   int stalls  = 0;

   hazard_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) dut (
      .Clock(Clock), .Reset(Reset),
      .RsAddrD(RsAddrD), .RtAddrD(RtAddrD), .UsesRsD(UsesRsD), .UsesRtD(UsesRtD),
      .RsAddrE(RsAddrE), .RtAddrE(RtAddrE), .RAddrE(RAddrE), .RegWriteE(RegWriteE),
      .MemReadE(MemReadE), .MULOpE(MULOpE), .BranchTakenE(BranchTakenE),
      .RAddrM(RAddrM), .RegWriteM(RegWriteM), .RAddrW(RAddrW), .RegWriteW(RegWriteW),
      .MemBusyM(MemBusyM),
      .HoldPC(HoldPC), .HoldFD(HoldFD), .HoldDE(HoldDE), .HoldEM(HoldEM),
      .FlushFD(FlushFD), .FlushDE(FlushDE), .FlushEM(FlushEM), .FlushMW(FlushMW),
      .FwdA(FwdA), .FwdB(FwdB), .MulBusy(MulBusy), .StallCycles(StallCycles)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Newest producer first: MEM, then WB; r0 is a constant and never supplies data.
   function automatic logic [1:0] model_fwd(input logic [4:0] src);
      logic [4:0] dst [2];
      logic       wr  [2];
      logic [1:0] sel [2];
      dst[0] = RAddrM; wr[0] = RegWriteM; sel[0] = 2'b10;
      dst[1] = RAddrW; wr[1] = RegWriteW; sel[1] = 2'b01;
      for (int i = 0; i < 2; i++)
         if (wr[i] && dst[i] != 0 && dst[i] == src) return sel[i];
      return 2'b00;
   endfunction

   // hold = {PC,FD,DE,EM}, flush = {FD,DE,EM,MW}
   task automatic model_outputs(output logic [3:0] hold, output logic [3:0] flush,
                                output logic mul_busy);
      logic in_mul, mul_stall, load_use;
      in_mul    = (mul_age > 0) || MULOpE;
      mul_stall = in_mul && (mul_age < MUL_CYCLES - 1);
      load_use  = MemReadE && RegWriteE && RAddrE != 0 &&
                  ((UsesRsD && RsAddrD == RAddrE) || (UsesRtD && RtAddrD == RAddrE));
      hold  = 4'b0000;
      flush = 4'b0000;
      if (Reset)             flush = 4'b1111;
      else if (MemBusyM)     begin hold = 4'b1111; flush = 4'b0001; end
      else if (mul_stall)    begin hold = 4'b1110; flush = 4'b0010; end
      else if (BranchTakenE) flush = 4'b1100;
      else if (load_use)     begin hold = 4'b1100; flush = 4'b0100; end
      mul_busy = mul_stall && !Reset;
   endtask

   always @(posedge Clock) begin
      logic [3:0] h, f;
      logic       mb;
      if (Reset) begin
         mul_age = 0;
         stalls  = 0;
      end else begin
         model_outputs(h, f, mb);
         if (h[3] && stalls < CNT_MAX) stalls++;
         if (!MemBusyM && ((mul_age > 0) || MULOpE))
            mul_age = (mul_age >= MUL_CYCLES - 1) ? 0 : mul_age + 1;
      end
   end

   always @(negedge Clock) begin
      logic [3:0] h, f;
      logic       mb;
      model_outputs(h, f, mb);
      check("holds",   {HoldPC, HoldFD, HoldDE, HoldEM}, h);
      check("flushes", {FlushFD, FlushDE, FlushEM, FlushMW}, f);
      check("mulbusy", MulBusy, mb);
      check("fwda",    FwdA, Reset ? 2'b00 : model_fwd(RsAddrE));
      check("fwdb",    FwdB, Reset ? 2'b00 : model_fwd(RtAddrE));
      check("stalls",  StallCycles, stalls);
      check("hold_flush_excl", (HoldFD & FlushFD) | (HoldDE & FlushDE) | (HoldEM & FlushEM), 0);
   end

   task automatic clear_inputs();
      RsAddrD = 0; RtAddrD = 0; UsesRsD = 0; UsesRtD = 0;
      RsAddrE = 0; RtAddrE = 0; RAddrE = 0; RegWriteE = 0; MemReadE = 0;
      MULOpE = 0; BranchTakenE = 0; RAddrM = 0; RegWriteM = 0;
      RAddrW = 0; RegWriteW = 0; MemBusyM = 0;
   endtask

   task automatic advance();
      @(posedge Clock);
      #1;
   endtask

   task automatic set_load_use_r3();
      MemReadE = 1; RegWriteE = 1; RAddrE = 3; UsesRtD = 1; RtAddrD = 3;
   endtask

   initial begin
      clear_inputs();
      Reset = 1;
      RegWriteM = 1; RAddrM = 5; RsAddrE = 5;
      @(negedge Clock);
      check("rst_flush", {FlushFD, FlushDE, FlushEM, FlushMW}, 4'hF);
      check("rst_hold",  {HoldPC, HoldFD, HoldDE, HoldEM}, 4'h0);
      check("rst_fwda",  FwdA, 2'b00);
      check("rst_cnt",   StallCycles, 0);
      advance();
      Reset = 0;
      clear_inputs();

      // Forwarding priority and r0 exclusion
      RegWriteM = 1; RAddrM = 5; RsAddrE = 5; RegWriteW = 1; RAddrW = 5; RtAddrE = 7;
      @(negedge Clock);
      check("fwd_mem_wins", FwdA, 2'b10);
      check("fwd_b_none",   FwdB, 2'b00);
      advance();
      RAddrM = 0; RtAddrE = 5;
      @(negedge Clock);
      check("fwd_r0_m", FwdA, 2'b01);
      check("fwd_b_wb", FwdB, 2'b01);
      advance();
      RAddrW = 0;
      @(negedge Clock);
      check("fwd_r0_w", FwdA, 2'b00);
      advance();
      clear_inputs();

      // Load-use on Rt: one interlock cycle, then the load has moved on
      set_load_use_r3();
      @(negedge Clock);
      check("lu_hold",  {HoldPC, HoldFD, HoldDE}, 3'b110);
      check("lu_flush", {FlushFD, FlushDE, FlushEM}, 3'b010);
      advance();
      clear_inputs();
      @(negedge Clock);
      check("lu_after", {HoldPC, HoldFD, FlushDE}, 3'b000);
      check("lu_cnt",   StallCycles, 1);
      advance();

      // Load to r0 never interlocks
      MemReadE = 1; RegWriteE = 1; RAddrE = 0; UsesRtD = 1; RtAddrD = 0;
      @(negedge Clock);
      check("lu_r0", HoldPC, 1'b0);
      advance();
      clear_inputs();

      // Multiply: three stall cycles, free on the fourth
      MULOpE = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         check("mul_busy",    MulBusy, (i < 3));
         check("mul_hold",    {HoldPC, HoldFD, HoldDE, FlushEM}, (i < 3) ? 4'hF : 4'h0);
         advance();
      end
      clear_inputs();
      @(negedge Clock);
      check("mul_cnt", StallCycles, 4);
      advance();

      // Taken branch overrides a simultaneous load-use
      set_load_use_r3();
      BranchTakenE = 1;
      @(negedge Clock);
      check("br_flush", {FlushFD, FlushDE}, 2'b11);
      check("br_hold",  {HoldPC, HoldFD}, 2'b00);
      advance();
      clear_inputs();
      @(negedge Clock);
      check("br_cnt", StallCycles, 4);
      advance();

      // Memory wait during a multiply at Count=1 freezes it
      MULOpE = 1;
      advance();
      advance();
      MemBusyM = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge Clock);
         check("mb_hold",  {HoldPC, HoldFD, HoldDE, HoldEM}, 4'hF);
         check("mb_flush", {FlushFD, FlushDE, FlushEM, FlushMW}, 4'h1);
         advance();
      end
      MemBusyM = 0;
      @(negedge Clock);
      check("mb_resume", MulBusy, 1'b1);
      advance();
      @(negedge Clock);
      check("mb_free", MulBusy, 1'b0);
      advance();
      clear_inputs();
      @(negedge Clock);
      check("mb_cnt", StallCycles, 9);
      advance();

      // Reset in the middle of a multiply
      MULOpE = 1;
      advance();
      Reset = 1;
      @(negedge Clock);
      check("rmul_flush", {FlushFD, FlushDE, FlushEM, FlushMW}, 4'hF);
      check("rmul_hold",  {HoldPC, HoldFD, HoldDE, HoldEM}, 4'h0);
      advance();
      Reset = 0;
      MULOpE = 0;
      @(negedge Clock);
      check("rmul_idle", MulBusy, 1'b0);
      check("rmul_cnt",  StallCycles, 0);
      advance();

      // Mixed traffic, checked by the model alone
      for (int i = 0; i < 60; i++) begin
         RsAddrD   = 5'($urandom_range(0, 3)); RtAddrD   = 5'($urandom_range(0, 3));
         UsesRsD   = 1'($urandom_range(0, 1)); UsesRtD   = 1'($urandom_range(0, 1));
         RsAddrE   = 5'($urandom_range(0, 3)); RtAddrE   = 5'($urandom_range(0, 3));
         RAddrE    = 5'($urandom_range(0, 3)); RAddrM    = 5'($urandom_range(0, 3));
         RAddrW    = 5'($urandom_range(0, 3));
         RegWriteE = 1'($urandom_range(0, 1)); MemReadE  = 1'($urandom_range(0, 1));
         RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
         BranchTakenE = ($urandom_range(0, 3) == 0);
         MULOpE    = BranchTakenE ? 1'b0 : ($urandom_range(0, 4) == 0);
         MemBusyM  = ($urandom_range(0, 5) == 0);
         advance();
      end
      clear_inputs();

      // Long memory wait drives the counter into saturation
      MemBusyM = 1;
      repeat (CNT_MAX + 4) advance();
      @(negedge Clock);
      check("sat_cnt", StallCycles, CNT_MAX);
      advance();
      Reset = 1;
      @(negedge Clock);
      check("sat_rst_flush", {FlushFD, FlushDE, FlushEM, FlushMW}, 4'hF);
      check("sat_rst_hold",  {HoldPC, HoldFD, HoldDE, HoldEM}, 4'h0);
      advance();
      Reset = 0;
      clear_inputs();
      @(negedge Clock);
      check("sat_cleared", StallCycles, 0);
      advance();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
